controle_servo_multi: RTL and testbench

Multi-channel, parametrised successor of the single-servo PWM controller. It drives `CANAIS` hobby servos from one shared 20 ms period counter. Each channel has a `LARGURA_POS`-bit position, a per-channel enable, and updates that are applied only at period boundaries, so pulses never glitch. An optional slew-rate limiter moves each servo at most one position step per period.

---
 rtl/controle_servo_multi.sv | 107 ++++++++++
 tb/tb_controle_servo_multi.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_servo_multi.sv
// controle_servo_multi
// Multi-channel hobby-servo PWM controller. One shared period counter drives
// CANAIS channels; each channel's position and enable are captured only at the
// period boundary, so a pulse in progress is never cut short or stretched.
// Optional feature: define CONTROLE_SERVO_RAMPA_EN to move each channel at most
// one position step per period instead of jumping straight to the target.
module controle_servo_multi #(
    parameter int CANAIS       = 4,
    parameter int LARGURA_POS  = 3,
    parameter int PERIODO      = 1_000_000,
    parameter int LARGURA_BASE = 50_000,
    parameter int PASSO        = 5_556
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [CANAIS*LARGURA_POS-1:0] posicao,
    input  logic [CANAIS-1:0]             habilita,
    output logic [CANAIS-1:0]             controle,
    output logic [CANAIS-1:0]             estavel,
    output logic                          fim_periodo,
    output logic                          db_reset,
    output logic [LARGURA_POS-1:0]        db_posicao,
    output logic                          db_controle
);

    localparam int CW = $clog2(PERIODO);
    // One spare bit so a width equal to a power-of-two period still compares correctly.
    localparam int LW = CW + 1;
    localparam logic [CW-1:0] C_ULTIMO = CW'(PERIODO - 1);

    logic [CW-1:0]                      c_r;
    logic [CANAIS-1:0][LARGURA_POS-1:0] pos_apl_r;
    logic [CANAIS-1:0]                  hab_apl_r;
    logic [CANAIS-1:0]                  controle_r;
    logic                               fim_periodo_r;
    logic                               db_controle_r;

    logic [CANAIS-1:0][LARGURA_POS-1:0] alvo_s;
    logic [CANAIS-1:0][LARGURA_POS-1:0] pos_prox_s;
    logic [CANAIS-1:0]                  controle_prox_s;
    logic [CANAIS-1:0]                  estavel_s;
    logic                               ultimo_s;

    // High time in cycles for an applied position: base plus (pos+1) steps.
    function automatic logic [LW-1:0] largura_de(input logic [LARGURA_POS-1:0] pos);
        logic [LW-1:0] passos;
        passos = LW'(pos) + LW'(1'b1);
        return LW'(LARGURA_BASE) + passos * LW'(PASSO);
    endfunction

    // Per-channel target split, next applied position and next PWM level.
    always_comb begin
        ultimo_s        = (c_r == C_ULTIMO);
        alvo_s          = {(CANAIS*LARGURA_POS){1'b0}};
        pos_prox_s      = {(CANAIS*LARGURA_POS){1'b0}};
        controle_prox_s = {CANAIS{1'b0}};
        estavel_s       = {CANAIS{1'b0}};
        for (int i = 0; i < CANAIS; i++) begin
            alvo_s[i] = posicao[i*LARGURA_POS +: LARGURA_POS];
`ifdef CONTROLE_SERVO_RAMPA_EN
            if (pos_apl_r[i] < alvo_s[i]) begin
                pos_prox_s[i] = pos_apl_r[i] + LARGURA_POS'(1'b1);
            end else if (pos_apl_r[i] > alvo_s[i]) begin
                pos_prox_s[i] = pos_apl_r[i] - LARGURA_POS'(1'b1);
            end else begin
                pos_prox_s[i] = pos_apl_r[i];
            end
`else
            pos_prox_s[i] = alvo_s[i];
`endif
            // Pre-edge counter value: the output is high for c = 0 .. largura-1.
            controle_prox_s[i] = hab_apl_r[i] & ({1'b0, c_r} < largura_de(pos_apl_r[i]));
            estavel_s[i]       = (pos_apl_r[i] == alvo_s[i]);
        end
    end

    // Period counter, boundary capture of position/enable, registered PWM outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            c_r           <= {CW{1'b0}};
            pos_apl_r     <= {(CANAIS*LARGURA_POS){1'b0}};
            hab_apl_r     <= {CANAIS{1'b0}};
            controle_r    <= {CANAIS{1'b0}};
            fim_periodo_r <= 1'b0;
            db_controle_r <= 1'b0;
        end else begin
            if (ultimo_s) begin
                c_r       <= {CW{1'b0}};
                hab_apl_r <= habilita;
                pos_apl_r <= pos_prox_s;
            end else begin
                c_r       <= c_r + CW'(1'b1);
            end
            controle_r    <= controle_prox_s;
            fim_periodo_r <= ultimo_s;
            db_controle_r <= controle_prox_s[0];
        end
    end

    assign controle    = controle_r;
    assign estavel     = estavel_s;
    assign fim_periodo = fim_periodo_r;
    assign db_reset    = reset;
    assign db_posicao  = pos_apl_r[0];
    assign db_controle = db_controle_r;

endmodule

// File: tb/tb_controle_servo_multi.sv
// Testbench for controle_servo_multi: directed period measurements with
// hand-computed widths, then randomized stimulus, all checked every cycle
// against a time-based behavioural model of the servo channels.
module tb_controle_servo_multi;

    localparam int CANAIS       = 4;
    localparam int LARGURA_POS  = 3;
    localparam int PERIODO      = 100;
    localparam int LARGURA_BASE = 10;
    localparam int PASSO        = 5;

    localparam logic [11:0] P_INI = {3'd7, 3'd5, 3'd2, 3'd0};
    localparam logic [11:0] P_CH1 = {3'd7, 3'd5, 3'd5, 3'd0};
    localparam logic [11:0] P_R0  = {3'd7, 3'd0, 3'd0, 3'd0};
    localparam logic [11:0] P_R7  = {3'd7, 3'd0, 3'd0, 3'd7};

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] posicao;
    logic [3:0]  habilita;
    logic [3:0]  controle;
    logic [3:0]  estavel;
    logic        fim_periodo;
    logic        db_reset;
    logic [2:0]  db_posicao;
    logic        db_controle;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    controle_servo_multi #(
        .CANAIS      (CANAIS),
        .LARGURA_POS (LARGURA_POS),
        .PERIODO     (PERIODO),
        .LARGURA_BASE(LARGURA_BASE),
        .PASSO       (PASSO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .posicao    (posicao),
        .habilita   (habilita),
        .controle   (controle),
        .estavel    (estavel),
        .fim_periodo(fim_periodo),
        .db_reset   (db_reset),
        .db_posicao (db_posicao),
        .db_controle(db_controle)
    );

    task automatic chk(input string nome, input logic [31:0] real_v, input logic [31:0] esp);
        checks++;
        if (real_v !== esp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", nome, real_v, esp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_t = clock edges since the last reset edge. Period k (k>=1) uses the
    // inputs seen at edge k*PERIODO; period 0 is quiet.
    int m_t = 0;
    int app_pos[4];
    bit app_hab[4];
    bit chk_en = 1'b0;

    function automatic int largura(input int p);
        return LARGURA_BASE + (p + 1) * PASSO;
    endfunction

    // Model update on each rising edge from the inputs stable at that edge.
    always @(posedge clock) begin
        if (reset === 1'b0) begin
            m_t = 0;
            for (int i = 0; i < 4; i++) begin
                app_pos[i] = 0;
                app_hab[i] = 1'b0;
            end
            chk_en = 1'b1;
        end else begin
            m_t = m_t + 1;
            if (m_t % PERIODO == 0) begin
                for (int i = 0; i < 4; i++) begin
                    int alvo;
                    alvo = int'(posicao[i*LARGURA_POS +: LARGURA_POS]);
                    app_hab[i] = habilita[i];
`ifdef CONTROLE_SERVO_RAMPA_EN
                    if (app_pos[i] < alvo) app_pos[i] = app_pos[i] + 1;
                    else if (app_pos[i] > alvo) app_pos[i] = app_pos[i] - 1;
`else
                    app_pos[i] = alvo;
`endif
                end
            end
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clock) begin : comparador
        int ph;
        logic [3:0] e_ctrl;
        logic [3:0] e_est;
        if (chk_en) begin
            ph = m_t % PERIODO;
            for (int i = 0; i < 4; i++) begin
                e_ctrl[i] = app_hab[i] && (ph >= 1) && (ph <= largura(app_pos[i]));
                e_est[i]  = (app_pos[i] == int'(posicao[i*LARGURA_POS +: LARGURA_POS]));
            end
            chk("controle", controle, e_ctrl);
            chk("estavel", estavel, e_est);
            chk("fim_periodo", fim_periodo, (m_t > 0 && ph == 0));
            chk("db_reset", db_reset, reset);
            chk("db_posicao", db_posicao, app_pos[0]);
            chk("db_controle", db_controle, e_ctrl[0]);
        end
    end

    // ---------------- directed helpers ----------------
    int   alto[4];
    logic est0_ini;

    // Measure high cycles per channel over one whole period starting at fim_periodo;
    // optionally change the inputs right after sample j_mud.
    task automatic medir(input int j_mud, input logic [11:0] nova_pos, input logic [3:0] nova_hab);
        int espera;
        int nfim;
        espera = 0;
        nfim   = 0;
        for (int i = 0; i < 4; i++) alto[i] = 0;
        @(negedge clock);
        while (fim_periodo !== 1'b1 && espera < 2*PERIODO) begin
            @(negedge clock);
            espera++;
        end
        chk("espera_fim", fim_periodo, 1'b1);
        est0_ini = estavel[0];
        for (int j = 0; j < PERIODO; j++) begin
            if (j > 0) @(negedge clock);
            for (int i = 0; i < 4; i++) if (controle[i] === 1'b1) alto[i]++;
            if (fim_periodo === 1'b1) nfim++;
            if (j == j_mud) begin
                #1;
                posicao  = nova_pos;
                habilita = nova_hab;
            end
        end
        chk("fim_por_periodo", nfim, 1);
    endtask

    task automatic chk_larg(input int e0, input int e1, input int e2, input int e3);
        chk("largura_ch0", alto[0], e0);
        chk("largura_ch1", alto[1], e1);
        chk("largura_ch2", alto[2], e2);
        chk("largura_ch3", alto[3], e3);
    endtask

    // Count any pulse activity over one period right after reset release.
    task automatic quieto();
        int n;
        n = 0;
        for (int j = 0; j < PERIODO; j++) begin
            @(negedge clock);
            if (controle !== 4'b0000) n++;
        end
        chk("periodo_quieto", n, 0);
    endtask

    initial begin
        int espera;
        reset    = 1'b0;
        habilita = 4'b0000;
        posicao  = 12'd0;
        repeat (3) @(negedge clock);
        chk("reset_controle", controle, 4'b0000);
        chk("reset_fim", fim_periodo, 1'b0);
        chk("reset_db_posicao", db_posicao, 3'd0);
        chk("reset_db_reset", db_reset, 1'b0);
        #1;
        reset    = 1'b1;
        habilita = 4'b1111;
`ifdef CONTROLE_SERVO_RAMPA_EN
        posicao  = P_R0;
`else
        posicao  = P_INI;
`endif
        quieto();

`ifdef CONTROLE_SERVO_RAMPA_EN
        medir(-1, P_R0, 4'b1111);
        chk("rampa_ch0_inicio", alto[0], 15);
        medir(30, P_R7, 4'b1111);
        chk("rampa_ch0_mudanca", alto[0], 15);
        for (int k = 1; k <= 8; k++) begin
            medir(-1, P_R7, 4'b1111);
            chk("rampa_ch0", alto[0], 15 + 5 * ((k < 7) ? k : 7));
            chk("rampa_estavel0", est0_ini, (k >= 7));
        end
`else
        medir(-1, P_INI, 4'b1111);
        chk_larg(15, 25, 40, 50);
        medir(30, P_CH1, 4'b1111);
        chk_larg(15, 25, 40, 50);
        medir(-1, P_CH1, 4'b1111);
        chk_larg(15, 40, 40, 50);
        medir(10, P_CH1, 4'b1011);
        chk_larg(15, 40, 40, 50);
        medir(10, P_CH1, 4'b1111);
        chk_larg(15, 40, 0, 50);
        medir(-1, P_CH1, 4'b1111);
        chk_larg(15, 40, 40, 50);
`endif

        // Reset in the middle of a channel-3 pulse.
        espera = 0;
        @(negedge clock);
        while (fim_periodo !== 1'b1 && espera < 2*PERIODO) begin
            @(negedge clock);
            espera++;
        end
        chk("espera_fim_reset", fim_periodo, 1'b1);
        for (int j = 1; j <= 20; j++) @(negedge clock);
        chk("ch3_alto_c20", controle[3], 1'b1);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("ctrl_apos_reset", controle, 4'b0000);
        chk("fim_apos_reset", fim_periodo, 1'b0);
        chk("db_pos_apos_reset", db_posicao, 3'd0);
        #1;
        reset = 1'b1;
        quieto();
        medir(-1, posicao, habilita);
`ifdef CONTROLE_SERVO_RAMPA_EN
        chk("ch3_pos_reset", alto[3], 25);
`else
        chk("ch3_pos_reset", alto[3], 50);
`endif

        // Randomized phase: inputs change at arbitrary points, rare one-cycle resets.
        for (int n = 0; n < 4000; n++) begin
            @(negedge clock);
            #1;
            if ($urandom_range(0, 99) < 3) posicao = 12'($urandom);
            if ($urandom_range(0, 99) < 2) habilita = 4'($urandom);
            reset = ($urandom_range(0, 999) != 0);
        end
        @(negedge clock);
        #1;
        reset = 1'b1;
        repeat (2) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
